// File: rtl/ads_frame_fifo.sv
// rtl/ads_frame_fifo.sv - single-clock sample FIFO with frame-granular status
module ads_frame_fifo #(
  parameter int RAM_ADDR_WIDTH  = 10,
  parameter int RAM_DATA_WIDTH  = 32,
  parameter int FRAME_LEN       = 80,
  parameter int AFULL_THRESH    = (2**RAM_ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH   = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       sys_ce,
  input  logic [RAM_DATA_WIDTH-1:0]  hpf_audio_sample,
  input  logic                       hpf_smp_valid,
  input  logic                       ldb_read_en,
  input  logic                       aff_flush,
  input  logic                       aff_err_clr,
  output logic [RAM_DATA_WIDTH-1:0]  aff_read_data,
  output logic                       aff_read_valid,
  output logic [RAM_ADDR_WIDTH:0]    aff_data_count,
  output logic                       aff_data_full,
  output logic                       aff_data_empty,
  output logic                       aff_almost_full,
  output logic                       aff_almost_empty,
  output logic                       aff_frame_ready,
  output logic [FRAME_CNT_WIDTH-1:0] aff_frame_count,
  output logic                       aff_overflow,
  output logic                       aff_underflow
);

  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int CW    = RAM_ADDR_WIDTH + 1;
  localparam int DEPTH = 2**RAM_ADDR_WIDTH;
  localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] FRAME_C  = CW'(FRAME_LEN);
  localparam logic [FW-1:0] FLAST_C  = FW'(FRAME_LEN - 1);

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [FW-1:0]             frame_idx;
  logic [CW-1:0]             count_next;
  logic                      flush_acc;
  logic                      wr_acc;
  logic                      rd_acc;
  logic                      ovf_set;
  logic                      udf_set;

  // Full/empty come from the registered count, so a write at full is dropped
  // even when a read frees a slot in the same cycle.
  always_comb begin
    flush_acc  = sys_ce & aff_flush;
    wr_acc     = sys_ce & hpf_smp_valid & ~aff_data_full & ~aff_flush;
    rd_acc     = sys_ce & ldb_read_en & ~aff_data_empty & ~aff_flush;
    ovf_set    = sys_ce & hpf_smp_valid & aff_data_full & ~aff_flush;
    udf_set    = sys_ce & ldb_read_en & aff_data_empty & ~aff_flush;
    count_next = aff_data_count;
    if (flush_acc) begin
      count_next = '0;
    end else if (wr_acc && !rd_acc) begin
      count_next = aff_data_count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = aff_data_count - CW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= hpf_audio_sample;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      frame_idx        <= '0;
      aff_data_count   <= '0;
      aff_frame_count  <= '0;
      aff_read_data    <= '0;
      aff_read_valid   <= 1'b0;
      aff_overflow     <= 1'b0;
      aff_underflow    <= 1'b0;
      aff_data_full    <= 1'b0;
      aff_data_empty   <= 1'b1;
      aff_almost_full  <= ('0 >= AFULL_C);
      aff_almost_empty <= 1'b1;
      aff_frame_ready  <= 1'b0;
    end else begin
      aff_read_valid <= rd_acc;
      if (sys_ce) begin
        if (flush_acc) begin
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          frame_idx <= '0;
        end else begin
          if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (frame_idx == FLAST_C) begin
              frame_idx       <= '0;
              aff_frame_count <= aff_frame_count + FRAME_CNT_WIDTH'(1);
            end else begin
              frame_idx <= frame_idx + FW'(1);
            end
          end
          if (rd_acc) begin
            rd_ptr        <= rd_ptr + AW'(1);
            aff_read_data <= mem[rd_ptr];
          end
        end
        if (ovf_set) begin
          aff_overflow <= 1'b1;
        end else if (aff_err_clr) begin
          aff_overflow <= 1'b0;
        end
        if (udf_set) begin
          aff_underflow <= 1'b1;
        end else if (aff_err_clr) begin
          aff_underflow <= 1'b0;
        end
        aff_data_count   <= count_next;
        aff_data_full    <= (count_next == DEPTH_C);
        aff_data_empty   <= (count_next == '0);
        aff_almost_full  <= (count_next >= AFULL_C);
        aff_almost_empty <= (count_next <= AEMPTY_C);
        aff_frame_ready  <= (count_next >= FRAME_C);
      end
    end
  end

endmodule

// File: tb/tb_ads_frame_fifo.sv
// tb/tb_ads_frame_fifo.sv - self-checking bench for ads_frame_fifo
module tb_ads_frame_fifo;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int DEP  = 16;
  localparam int FLEN = 8;
  localparam int AFT  = 14;
  localparam int AET  = 2;
  localparam int FCW  = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           sys_ce;
  logic [DW-1:0]  hpf_audio_sample;
  logic           hpf_smp_valid;
  logic           ldb_read_en;
  logic           aff_flush;
  logic           aff_err_clr;
  logic [DW-1:0]  aff_read_data;
  logic           aff_read_valid;
  logic [AW:0]    aff_data_count;
  logic           aff_data_full;
  logic           aff_data_empty;
  logic           aff_almost_full;
  logic           aff_almost_empty;
  logic           aff_frame_ready;
  logic [FCW-1:0] aff_frame_count;
  logic           aff_overflow;
  logic           aff_underflow;

  ads_frame_fifo #(
    .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FRAME_LEN(FLEN),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_ce(sys_ce),
    .hpf_audio_sample(hpf_audio_sample), .hpf_smp_valid(hpf_smp_valid),
    .ldb_read_en(ldb_read_en), .aff_flush(aff_flush), .aff_err_clr(aff_err_clr),
    .aff_read_data(aff_read_data), .aff_read_valid(aff_read_valid),
    .aff_data_count(aff_data_count), .aff_data_full(aff_data_full),
    .aff_data_empty(aff_data_empty), .aff_almost_full(aff_almost_full),
    .aff_almost_empty(aff_almost_empty), .aff_frame_ready(aff_frame_ready),
    .aff_frame_count(aff_frame_count), .aff_overflow(aff_overflow),
    .aff_underflow(aff_underflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        wv;
    logic [31:0] d;
    logic        re;
    logic        fl;
    logic        clr;
    logic        ce;
    int          exp_cnt;
    logic        exp_val;
    logic        exp_udf;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] mq [$];
  logic [31:0] sb [$];
  int          fidx;
  int          fcnt;
  logic        movf;
  logic        mudf;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    fidx = 0;
    fcnt = 0;
    movf = 1'b0;
    mudf = 1'b0;
  endtask

  task automatic check_status();
    int c;
    c = mq.size();
    chk("count", 32'(aff_data_count), 32'(c));
    chk("full", aff_data_full, c == DEP);
    chk("empty", aff_data_empty, c == 0);
    chk("almost_full", aff_almost_full, c >= AFT);
    chk("almost_empty", aff_almost_empty, c <= AET);
    chk("frame_ready", aff_frame_ready, c >= FLEN);
    chk("frame_count", 32'(aff_frame_count), 32'(fcnt));
    chk("overflow", aff_overflow, movf);
    chk("underflow", aff_underflow, mudf);
  endtask

  // One clock: drive at negedge, update the model, check at the next negedge.
  task automatic cycle(input logic wv, input logic [31:0] d, input logic re,
                       input logic fl, input logic clr, input logic ce);
    logic wa, ra, full, empty;
    hpf_smp_valid    = wv;
    hpf_audio_sample = d;
    ldb_read_en      = re;
    aff_flush        = fl;
    aff_err_clr      = clr;
    sys_ce           = ce;
    full  = (mq.size() == DEP);
    empty = (mq.size() == 0);
    wa = ce & wv & ~full & ~fl;
    ra = ce & re & ~empty & ~fl;
    if (ce) begin
      if (wv & full & ~fl) movf = 1'b1;
      else if (clr) movf = 1'b0;
      if (re & empty & ~fl) mudf = 1'b1;
      else if (clr) mudf = 1'b0;
      if (fl) begin
        mq.delete();
        fidx = 0;
      end else begin
        if (ra) sb.push_back(mq.pop_front());
        if (wa) begin
          mq.push_back(d);
          if (fidx == FLEN - 1) begin
            fidx = 0;
            fcnt = (fcnt + 1) % 65536;
          end else begin
            fidx++;
          end
        end
      end
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("read_valid", aff_read_valid, ra);
    if (aff_read_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL read_data: got %0h, expected no read", aff_read_data);
      end else begin
        chk("read_data", aff_read_data, sb.pop_front());
      end
    end
    check_status();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    sys_rst_n = 1'b0;
    sys_ce = 1'b1;
    hpf_audio_sample = '0;
    hpf_smp_valid = 1'b0;
    ldb_read_en = 1'b0;
    aff_flush = 1'b0;
    aff_err_clr = 1'b0;

    tbl[0] = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};

    repeat (2) @(negedge sys_clk);
    chk("rst_valid", aff_read_valid, 1'b0);
    chk("rst_data", aff_read_data, 32'h0);
    check_status();
    sys_rst_n = 1'b1;
    idle();

    // Fill and drain
    for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill_frames", 32'(aff_frame_count), 32'd2);
    chk("fill_full", aff_data_full, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", aff_data_empty, 1'b1);

    // Overflow: write at full with a simultaneous read
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovf_count", 32'(aff_data_count), 32'd15);
    chk("ovf_flag", aff_overflow, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (aff_read_valid) chk("no_dead", 32'(aff_read_data == 32'hDEAD), 32'd0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", aff_overflow, 1'b0);

    // Underflow and simultaneous events
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].wv, tbl[i].d, tbl[i].re, tbl[i].fl, tbl[i].clr, tbl[i].ce);
      chk($sformatf("tbl%0d_cnt", i), 32'(aff_data_count), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_valid", i), aff_read_valid, tbl[i].exp_val);
      chk($sformatf("tbl%0d_udf", i), aff_underflow, tbl[i].exp_udf);
    end

    // Wrap-around with 8 samples in flight
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 8; i < 48; i++) begin
      cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk("wrap_count", 32'(aff_data_count), 32'd8);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Flush while writing and reading
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    fcnt = fcnt;
    cycle(1'b1, 32'h3FF, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_count", 32'(aff_data_count), 32'd0);
    chk("flush_valid", aff_read_valid, 1'b0);

    // Clock enable low with requests held high
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hBAD0 + 32'(i), 1'b1, 1'b1, 1'b1, 1'b0);
      chk("ce_count", 32'(aff_data_count), 32'd2);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream with count 9 and a read in flight
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_count", 32'(aff_data_count), 32'd9);
    ldb_read_en = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", aff_read_valid, 1'b0);
    chk("arst_data", aff_read_data, 32'h0);
    check_status();
    @(negedge sys_clk);
    ldb_read_en = 1'b0;
    chk("arst_hold_valid", aff_read_valid, 1'b0);
    sys_rst_n = 1'b1;
    idle();
    cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
